// File: rtl/rx_controller.sv
// Register-access command decoder for the UART packet stream.
// Accepts write/read packets addressed to DEVICE_ADDRESS and issues one-cycle bus strobes.
module rx_controller #(
    parameter logic [7:0] DEVICE_ADDRESS = 8'h01
) (
    input  logic        ipClk,
    input  logic        ipReset,
    input  logic        ipRxValid,
    input  logic        ipRxSoP,
    input  logic        ipRxEoP,
    input  logic [7:0]  ipRxLength,
    input  logic [7:0]  ipRxDestination,
    input  logic [7:0]  ipRxSource,
    input  logic [7:0]  ipRxData,
    output logic        opRxReady,
    output logic [7:0]  opAddress,
    output logic [31:0] opWrData,
    output logic        opWrEnable,
    output logic        opRdEnable,
    output logic [7:0]  opSource,
    output logic [7:0]  opErrorCount
);

    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD, ISSUE} state_t;

    state_t      state;
    logic [7:0]  rx_len;
    logic [7:0]  rx_src;
    logic [7:0]  rx_cmd;
    logic [7:0]  rx_addr;
    logic [23:0] rx_data;
    logic [2:0]  idx;

    logic        accept;
    logic        sop_dest_ok;
    logic        sop_len_ok;
    logic        sop_err;
    state_t      sop_state;
    logic [7:0]  count;
    logic        pkt_good;
    logic        issue_now;
    logic [1:0]  err_inc;
    logic [8:0]  err_sum;

    assign accept = ipRxValid && opRxReady;

    // A start-of-packet beat is decoded the same way from IDLE, COLLECT and DISCARD.
    always_comb begin
        sop_dest_ok = (ipRxDestination == DEVICE_ADDRESS);
        sop_len_ok  = (ipRxLength == 8'd2) || (ipRxLength == 8'd6);
        sop_err     = sop_dest_ok && (!sop_len_ok || ipRxEoP);
        if (ipRxEoP)
            sop_state = IDLE;
        else if (!sop_dest_ok || !sop_len_ok)
            sop_state = DISCARD;
        else
            sop_state = COLLECT;
    end

    always_comb begin
        count    = {5'd0, idx} + 8'd1;
        pkt_good = (count == rx_len) &&
                   (((rx_cmd == 8'h01) && (rx_len == 8'd6)) ||
                    ((rx_cmd == 8'h00) && (rx_len == 8'd2)));
        issue_now = accept && (state == COLLECT) && !ipRxSoP && ipRxEoP && pkt_good;
    end

    // An SoP inside COLLECT can cost two errors: the abandoned packet plus a bad new header.
    always_comb begin
        err_inc = '0;
        if (accept) begin
            case (state)
                IDLE, DISCARD: begin
                    if (ipRxSoP)
                        err_inc = {1'b0, sop_err};
                end
                COLLECT: begin
                    if (ipRxSoP)
                        err_inc = sop_err ? 2'd2 : 2'd1;
                    else if (ipRxEoP)
                        err_inc = {1'b0, !pkt_good};
                    else if (count == rx_len)
                        err_inc = 2'd1;
                end
                default: err_inc = '0;
            endcase
        end
        err_sum = {1'b0, opErrorCount} + {7'd0, err_inc};
    end

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state        <= IDLE;
            rx_len       <= '0;
            rx_src       <= '0;
            rx_cmd       <= '0;
            rx_addr      <= '0;
            rx_data      <= '0;
            idx          <= '0;
            opRxReady    <= 1'b0;
            opAddress    <= '0;
            opWrData     <= '0;
            opWrEnable   <= 1'b0;
            opRdEnable   <= 1'b0;
            opSource     <= '0;
            opErrorCount <= '0;
        end else begin
            opWrEnable <= 1'b0;
            opRdEnable <= 1'b0;
            opRxReady  <= !issue_now;
            if (err_inc != 2'd0)
                opErrorCount <= err_sum[8] ? 8'hFF : err_sum[7:0];

            case (state)
                IDLE, DISCARD: begin
                    if (accept) begin
                        if (ipRxSoP) begin
                            rx_len <= ipRxLength;
                            rx_src <= ipRxSource;
                            rx_cmd <= ipRxData;
                            idx    <= 3'd1;
                            state  <= sop_state;
                        end else if (state == DISCARD && ipRxEoP) begin
                            state <= IDLE;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (ipRxSoP) begin
                            rx_len <= ipRxLength;
                            rx_src <= ipRxSource;
                            rx_cmd <= ipRxData;
                            idx    <= 3'd1;
                            state  <= sop_state;
                        end else begin
                            case (idx)
                                3'd1:    rx_addr        <= ipRxData;
                                3'd2:    rx_data[7:0]   <= ipRxData;
                                3'd3:    rx_data[15:8]  <= ipRxData;
                                3'd4:    rx_data[23:16] <= ipRxData;
                                default: ;
                            endcase
                            idx <= idx + 3'd1;
                            if (ipRxEoP) begin
                                if (pkt_good) begin
                                    state    <= ISSUE;
                                    opSource <= rx_src;
                                    // The EoP beat carries the last byte, so it is merged in directly.
                                    if (rx_cmd == 8'h01) begin
                                        opWrEnable <= 1'b1;
                                        opAddress  <= rx_addr;
                                        opWrData   <= {ipRxData, rx_data};
                                    end else begin
                                        opRdEnable <= 1'b1;
                                        opAddress  <= ipRxData;
                                    end
                                end else begin
                                    state <= IDLE;
                                end
                            end else if (count == rx_len) begin
                                state <= DISCARD;
                            end
                        end
                    end
                end
                ISSUE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_controller.sv
// Directed bench for rx_controller: expected strobes are queued as packets are driven
// and popped when the DUT raises opWrEnable/opRdEnable.
module tb_rx_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        sop = 1'b0;
    logic        eop = 1'b0;
    logic [7:0]  len = '0;
    logic [7:0]  dest = '0;
    logic [7:0]  src = '0;
    logic [7:0]  data = '0;
    logic        ready;
    logic [7:0]  address;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  source;
    logic [7:0]  err_count;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [7:0]  src;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned held;
    int unsigned exp_err;

    rx_controller #(.DEVICE_ADDRESS(8'h01)) dut (
        .ipClk          (clk),
        .ipReset        (rst),
        .ipRxValid      (valid),
        .ipRxSoP        (sop),
        .ipRxEoP        (eop),
        .ipRxLength     (len),
        .ipRxDestination(dest),
        .ipRxSource     (src),
        .ipRxData       (data),
        .opRxReady      (ready),
        .opAddress      (address),
        .opWrData       (wr_data),
        .opWrEnable     (wr_en),
        .opRdEnable     (rd_en),
        .opSource       (source),
        .opErrorCount   (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (wr_en || rd_en) begin
            chk("both_strobes", 64'(wr_en && rd_en), 64'(0));
            chk("ready_in_issue", 64'(ready), 64'(0));
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("strobe_kind", 64'(wr_en), 64'(e.wr));
                chk("strobe_addr", 64'(address), 64'(e.addr));
                chk("strobe_data", 64'(wr_data), 64'(e.data));
                chk("strobe_source", 64'(source), 64'(e.src));
            end
        end
    endtask

    task automatic send_beat(input logic s, input logic e, input logic [7:0] l,
                             input logic [7:0] d, input logic [7:0] so,
                             input logic [7:0] b, output int unsigned waits);
        valid = 1'b1; sop = s; eop = e; len = l; dest = d; src = so; data = b;
        waits = 0;
        while (!ready && waits < 20) begin
            tick();
            waits++;
        end
        if (!ready) chk("ready_timeout", 64'(0), 64'(1));
        tick();
        valid = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] d, input logic [7:0] so, input logic [7:0] l,
                            input int unsigned n, input logic [63:0] bytes,
                            input logic eop_last, output int unsigned first_wait);
        int unsigned w;
        first_wait = 0;
        for (int unsigned i = 0; i < n; i++) begin
            send_beat(i == 0, eop_last && (i == n - 1), l, d, so, bytes[8*i +: 8], w);
            if (i == 0) first_wait = w;
        end
    endtask

    task automatic push(input logic w, input logic [7:0] a, input logic [31:0] dv, input logic [7:0] s);
        exp_t e;
        e.wr = w; e.addr = a; e.data = dv; e.src = s;
        sb.push_back(e);
    endtask

    initial begin
        // Reset behaviour
        tick();
        chk("rst_ready", 64'(ready), 64'(0));
        chk("rst_wr", 64'(wr_en), 64'(0));
        chk("rst_rd", 64'(rd_en), 64'(0));
        chk("rst_err", 64'(err_count), 64'(0));
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 64'(ready), 64'(1));

        // Write packet
        push(1'b1, 8'h10, 32'h12345678, 8'hA1);
        send_pkt(8'h01, 8'hA1, 8'd6, 6, 64'h0000_1234_5678_1001, 1'b1, held);
        chk("wr_en", 64'(wr_en), 64'(1));
        chk("wr_addr", 64'(address), 64'(8'h10));
        chk("wr_data", 64'(wr_data), 64'(32'h12345678));
        chk("wr_rd_low", 64'(rd_en), 64'(0));
        chk("wr_ready_low", 64'(ready), 64'(0));
        chk("wr_err", 64'(err_count), 64'(0));
        tick();
        chk("wr_one_cycle", 64'(wr_en), 64'(0));
        chk("sb_empty_wr", 64'(sb.size()), 64'(0));

        // Read, then a back-to-back write held off by ready=0
        push(1'b0, 8'h2A, 32'h12345678, 8'hB2);
        send_pkt(8'h01, 8'hB2, 8'd2, 2, 64'h2A00, 1'b1, held);
        chk("rd_en", 64'(rd_en), 64'(1));
        chk("rd_addr", 64'(address), 64'(8'h2A));
        push(1'b1, 8'h20, 32'hCAFEF00D, 8'hB3);
        send_pkt(8'h01, 8'hB3, 8'd6, 6, 64'h0000_CAFE_F00D_2001, 1'b1, held);
        chk("b2b_held", 64'(held), 64'(1));
        tick();
        chk("sb_empty_b2b", 64'(sb.size()), 64'(0));

        // Foreign destination, then a valid read
        send_pkt(8'h05, 8'hC4, 8'd6, 6, 64'h0000_0403_0201_3301, 1'b1, held);
        tick();
        chk("foreign_err", 64'(err_count), 64'(0));
        chk("foreign_no_strobe", 64'(sb.size()), 64'(0));
        push(1'b0, 8'h2B, 32'hCAFEF00D, 8'hC5);
        send_pkt(8'h01, 8'hC5, 8'd2, 2, 64'h2B00, 1'b1, held);
        tick();
        chk("sb_empty_foreign", 64'(sb.size()), 64'(0));

        // Malformed packets
        exp_err = 0;
        send_pkt(8'h01, 8'hD1, 8'd6, 4, 64'hBBAA_2001, 1'b1, held);
        tick();
        exp_err++;
        chk("short_err", 64'(err_count), 64'(exp_err));
        send_pkt(8'h01, 8'hD2, 8'd3, 3, 64'h11_3000, 1'b1, held);
        tick();
        exp_err++;
        chk("len3_err", 64'(err_count), 64'(exp_err));
        send_pkt(8'h01, 8'hD3, 8'd6, 6, 64'h0000_0403_0201_4000, 1'b1, held);
        tick();
        exp_err++;
        chk("rd_len6_err", 64'(err_count), 64'(exp_err));
        chk("sb_empty_bad", 64'(sb.size()), 64'(0));

        // Reset mid-write
        send_pkt(8'h01, 8'hE1, 8'd6, 3, 64'h33_5501, 1'b0, held);
        rst = 1'b1;
        tick();
        chk("midrst_ready", 64'(ready), 64'(0));
        chk("midrst_addr", 64'(address), 64'(0));
        chk("midrst_data", 64'(wr_data), 64'(0));
        chk("midrst_source", 64'(source), 64'(0));
        chk("midrst_err", 64'(err_count), 64'(0));
        rst = 1'b0;
        tick();
        chk("midrst_ready_back", 64'(ready), 64'(1));
        chk("midrst_no_strobe", 64'(wr_en || rd_en), 64'(0));

        // SoP mid-packet aborts the write
        send_pkt(8'h01, 8'hF1, 8'd6, 3, 64'h11_5001, 1'b0, held);
        push(1'b0, 8'h44, 32'h0, 8'h77);
        send_pkt(8'h01, 8'h77, 8'd2, 2, 64'h4400, 1'b1, held);
        chk("abort_rd_en", 64'(rd_en), 64'(1));
        chk("abort_err", 64'(err_count), 64'(1));
        tick();
        chk("sb_empty_abort", 64'(sb.size()), 64'(0));

        // Saturation
        exp_err = 1;
        for (int unsigned i = 0; i < 300; i++) begin
            send_beat(1'b1, 1'b1, 8'd6, 8'h01, 8'h99, 8'h01, held);
            if (exp_err < 255) exp_err++;
        end
        tick();
        chk("sat_err", 64'(err_count), 64'(exp_err));
        chk("sat_ff", 64'(err_count), 64'(8'hFF));
        chk("sb_empty_end", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
